complete_arbiter: RTL and testbench

Arbitrates completion reports from the out-of-order pipeline's functional units (ALU, multiplier, load/store) onto the reorder buffer's single completion port (complete, rob_number, jb_addr, changeFlow). Each requester has a one-entry holding slot. Slots are drained one per cycle by a round-robin arbiter that gives jump/branch redirects priority. The block suppresses duplicate redirects while one is outstanding, and it flushes all held completions while the reorder buffer rolls back.

---
 rtl/complete_arbiter.sv | 138 +++++++++++++
 tb/tb_complete_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/complete_arbiter.sv
// Completion arbiter: per-unit one-entry slots, round-robin drain with redirect priority; 2 cycles valid->ROB.
// Backpressure: req_ready drops while a slot is held and not granted, and everywhere during reset/recover.
module complete_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ROB_W  = 4,
  parameter int ADDR_W = 32,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ROB_W-1:0]  req_rob,
  input  logic [N_REQ*ADDR_W-1:0] req_jb_addr,
  input  logic [N_REQ-1:0]        req_changeFlow,
  input  logic                    recover,
  output logic                    complete,
  output logic [ROB_W-1:0]        rob_number,
  output logic [ADDR_W-1:0]       jb_addr,
  output logic                    changeFlow,
  output logic [IDW-1:0]          grant_id
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t state;
  state_t state_nxt;

  logic [N_REQ-1:0]  occ;
  logic [N_REQ-1:0]  slot_cf;
  logic [ROB_W-1:0]  slot_rob  [N_REQ];
  logic [ADDR_W-1:0] slot_addr [N_REQ];
  logic [IDW-1:0]    rr_ptr;
  logic              cf_pending;

  logic              accept_en;
  logic [N_REQ-1:0]  cf_cand;
  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  hs;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    idx;
  logic              found;
  logic              any_gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // recover dominates: it blocks both acceptance and grant in the cycle it is seen
  always_comb begin
    state_nxt = state;
    accept_en = 1'b0;
    case (state)
      RUN: begin
        accept_en = ~rst & ~recover;
        if (recover) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!recover) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // a held redirect waits while one is outstanding; plain completions still drain
  always_comb begin
    cf_cand = occ & slot_cf & {N_REQ{~cf_pending}};
    cand    = (|cf_cand) ? cf_cand : (occ & ~slot_cf);
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = IDW'((int'(rr_ptr) + off) % N_REQ);
      if (!found && cand[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found && accept_en) gnt[gnt_idx] = 1'b1;
  end

  assign any_gnt   = |gnt;
  assign req_ready = {N_REQ{accept_en}} & (~occ | gnt);
  assign hs        = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= '0;
      slot_cf    <= '0;
      rr_ptr     <= '0;
      cf_pending <= 1'b0;
      complete   <= 1'b0;
      rob_number <= '0;
      jb_addr    <= '0;
      changeFlow <= 1'b0;
      grant_id   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_rob[i]  <= '0;
        slot_addr[i] <= '0;
      end
    end else begin
      complete   <= any_gnt;
      rob_number <= any_gnt ? slot_rob[gnt_idx] : '0;
      changeFlow <= any_gnt & slot_cf[gnt_idx];
      jb_addr    <= (any_gnt && slot_cf[gnt_idx]) ? slot_addr[gnt_idx] : '0;
      grant_id   <= any_gnt ? gnt_idx : '0;

      if (any_gnt) begin
        rr_ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end

      if (state == FLUSH) begin
        occ        <= '0;
        cf_pending <= 1'b0;
      end else begin
        if (any_gnt && slot_cf[gnt_idx]) cf_pending <= 1'b1;
        // a same-edge refill wins over the clear of the granted slot
        for (int i = 0; i < N_REQ; i++) begin
          if (hs[i]) begin
            occ[i]       <= 1'b1;
            slot_cf[i]   <= req_changeFlow[i];
            slot_rob[i]  <= req_rob[i*ROB_W +: ROB_W];
            slot_addr[i] <= req_jb_addr[i*ADDR_W +: ADDR_W];
          end else if (gnt[i]) begin
            occ[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Bench for complete_arbiter: per-cycle vector table with a scoreboard of expected ROB-port outputs.
module tb_complete_arbiter;
  localparam int N  = 3;
  localparam int RW = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            recover;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_changeFlow;
  logic [N*RW-1:0] req_rob;
  logic [N*AW-1:0] req_jb_addr;
  logic            complete;
  logic [RW-1:0]   rob_number;
  logic [AW-1:0]   jb_addr;
  logic            changeFlow;
  logic [1:0]      grant_id;

  complete_arbiter #(.N_REQ(N), .ROB_W(RW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rob(req_rob), .req_jb_addr(req_jb_addr), .req_changeFlow(req_changeFlow),
    .recover(recover),
    .complete(complete), .rob_number(rob_number), .jb_addr(jb_addr),
    .changeFlow(changeFlow), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        c;
    logic [3:0]  rob;
    logic        cf;
    logic [31:0] addr;
    logic [1:0]  gid;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       rec;
    logic [2:0] vld;
    logic [2:0] cf;
    logic [11:0] robs;
    logic [2:0] rdy;
    out_t       exp;
  } vec_t;

  // fixed per-requester redirect targets (requester 2 uses 32'h10)
  localparam logic [95:0] ADDRS = {32'h0000_0010, 32'h0000_0200, 32'h0000_0100};

  vec_t tbl[$];
  out_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(string n, logic rs, logic rc, logic [2:0] v, logic [2:0] cfv,
                              logic [3:0] r0, logic [3:0] r1, logic [3:0] r2, logic [2:0] rdy,
                              logic c, logic [3:0] rob, logic cf, logic [31:0] a, logic [1:0] g);
    vec_t t;
    t.name = n; t.rst = rs; t.rec = rc; t.vld = v; t.cf = cfv;
    t.robs = {r2, r1, r0}; t.rdy = rdy;
    t.exp  = '{c: c, rob: rob, cf: cf, addr: a, gid: g};
    return t;
  endfunction

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", n, got, exp);
  endtask

  task automatic run_vec(vec_t v);
    out_t got;
    out_t exp;
    rst = v.rst; recover = v.rec; req_valid = v.vld; req_changeFlow = v.cf;
    req_rob = v.robs;
    #1;
    chk({v.name, ".ready"}, 64'(req_ready), 64'(v.rdy));
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    got = '{c: complete, rob: rob_number, cf: changeFlow, addr: jb_addr, gid: grant_id};
    exp = sb.pop_front();
    chk({v.name, ".out"}, 64'(got), 64'(exp));
  endtask

  initial begin
    int lat;
    rst = 1'b1; recover = 1'b0; req_valid = '0; req_changeFlow = '0;
    req_rob = '0; req_jb_addr = ADDRS;

    //              name      rst rec vld    cf     r0 r1 r2  rdy   c rob cf addr           gid
    tbl.push_back(mk("rst0",   1, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    // single request, 2-cycle latency, one-cycle pulse
    tbl.push_back(mk("s_load", 0, 0, 3'b001, 3'b000, 2, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("s_out",  0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 1, 2, 0, 32'h0,        0));
    tbl.push_back(mk("s_idle", 0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    // fairness from rr_ptr=0; F7 refills slot 2 with rob 12 while it is granted
    tbl.push_back(mk("f_rst",  1, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("f1",     0, 0, 3'b111, 3'b000, 1, 2, 3, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("f2",     0, 0, 3'b111, 3'b000, 1, 2, 3, 3'b001, 1, 1, 0, 32'h0,        0));
    tbl.push_back(mk("f3",     0, 0, 3'b111, 3'b000, 1, 2, 3, 3'b010, 1, 2, 0, 32'h0,        1));
    tbl.push_back(mk("f4",     0, 0, 3'b111, 3'b000, 1, 2, 3, 3'b100, 1, 3, 0, 32'h0,        2));
    tbl.push_back(mk("f5",     0, 0, 3'b111, 3'b000, 1, 2, 3, 3'b001, 1, 1, 0, 32'h0,        0));
    tbl.push_back(mk("f6",     0, 0, 3'b111, 3'b000, 1, 2, 3, 3'b010, 1, 2, 0, 32'h0,        1));
    tbl.push_back(mk("f7",     0, 0, 3'b111, 3'b000, 1, 2,12, 3'b100, 1, 3, 0, 32'h0,        2));
    tbl.push_back(mk("f8",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b001, 1, 1, 0, 32'h0,        0));
    tbl.push_back(mk("f9",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b011, 1, 2, 0, 32'h0,        1));
    tbl.push_back(mk("f10",    0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 1,12, 0, 32'h0,        2));
    tbl.push_back(mk("f11",    0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    // redirect priority, jb_addr zero for non-redirects
    tbl.push_back(mk("p1",     0, 0, 3'b101, 3'b100, 5, 0, 3, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("p2",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b110, 1, 3, 1, 32'h10,       2));
    tbl.push_back(mk("p3",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 1, 5, 0, 32'h0,        0));
    tbl.push_back(mk("p4",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    // short rollback to clear the outstanding redirect
    tbl.push_back(mk("r1",     0, 1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("r2",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("r3",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    // two redirects held: one issues, the other waits and is flushed
    tbl.push_back(mk("d1",     0, 0, 3'b011, 3'b011, 7, 8, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d2",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b110, 1, 8, 1, 32'h200,      1));
    tbl.push_back(mk("d3",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b110, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d4",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b110, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d5",     0, 1, 3'b111, 3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d6",     0, 1, 3'b111, 3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d7",     0, 1, 3'b111, 3'b000, 1, 1, 1, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d8",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d9",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("d10",    0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    // recover beats grant (rr_ptr=2 here)
    tbl.push_back(mk("g1",     0, 0, 3'b001, 3'b000, 9, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("g2",     0, 1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("g3",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("g4",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("g5",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    // reset mid-stream with rr_ptr=1, then rr_ptr must restart at 0
    tbl.push_back(mk("m1",     0, 0, 3'b111, 3'b000, 4, 5, 6, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("m2",     0, 0, 3'b111, 3'b000, 4, 5, 6, 3'b100, 1, 6, 0, 32'h0,        2));
    tbl.push_back(mk("m3",     0, 0, 3'b111, 3'b000, 4, 5, 6, 3'b001, 1, 4, 0, 32'h0,        0));
    tbl.push_back(mk("m4",     1, 0, 3'b111, 3'b000, 4, 5, 6, 3'b000, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("m5",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("m6",     0, 0, 3'b111, 3'b000, 4, 5, 6, 3'b111, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk("m7",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b001, 1, 4, 0, 32'h0,        0));
    tbl.push_back(mk("m8",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b011, 1, 5, 0, 32'h0,        1));
    tbl.push_back(mk("m9",     0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 1, 6, 0, 32'h0,        2));
    tbl.push_back(mk("m10",    0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0));

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) run_vec(tbl[i]);

    // hand-written: bounded wait for a lone redirect from requester 1
    req_valid = 3'b010; req_changeFlow = 3'b010; req_rob = {4'h0, 4'hB, 4'h0};
    @(posedge clk);
    #1;
    req_valid = '0; req_changeFlow = '0;
    lat = 0;
    while (!complete && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hand.latency", 64'(lat), 64'd1);
    chk("hand.out", 64'({complete, rob_number, changeFlow, jb_addr, grant_id}),
        64'({1'b1, 4'hB, 1'b1, 32'h200, 2'd1}));
    @(posedge clk);
    #1;
    chk("hand.pulse", 64'(complete), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish required finish by 20000");
    $fatal(1);
  end

endmodule
